serial_alu_ctrl: RTL
====================

# serial_alu_ctrl

Bit-serial sequencer that computes a WIDTH-bit MIPS-style ALU operation using one external 1-bit ALU slice, one bit per clock. It decodes a 4-bit ALU control code into the slice controls (ainvert, binvert, cin, less, s) and feeds operand bits LSB-first. It carries the ripple carry between cycles and assembles the result, zero and overflow. It sits between the issue logic, via a start/done handshake, and a single shared `smallalu`-style slice.

## Interface
- WIDTH, 32: operand/result width; legal range 2..64.

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  4  ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR; all other codes are illegal
- a  in  WIDTH  operand A, captured on the accepting edge
- b  in  WIDTH  operand B, captured on the accepting edge
- busy  out  1  high in RUN and SLT_FIX
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  final result, held until the next completion
- zero  out  1  result == 0, registered with result
- overflow  out  1  signed overflow for ADD/SUB; 0 for all other ops
- slice_a, slice_b  out  1  operand bits for the current bit index
- slice_ainvert, slice_binvert, slice_cin, slice_less  out  1  slice controls
- slice_s  out  2  slice mux select: 00 AND, 01 OR, 10 sum, 11 less
- slice_result, slice_cout  in  1  slice outputs, combinational from the slice_* outputs

## Operation
- States: IDLE, RUN, SLT_FIX, DONE.
- IDLE: start=1 captures a, b and op, clears cnt, and goes to RUN.
- IDLE: start=0 stays in IDLE.
- RUN, slice drive by op:
  - AND: s=00.
  - OR: s=01.
  - ADD: s=10, binvert=0.
  - SUB and SLT: s=10, binvert=1.
  - NOR: s=00, ainvert=1, binvert=1.
  - Illegal op: s=00 with slice_a forced 0, so result is 0.
- RUN, operand bits: slice_a=A[cnt], slice_b=B[cnt].
- RUN, carry in: at cnt=0, slice_cin=1 for SUB/SLT and 0 otherwise. At cnt>0, slice_cin=the carry register.
- RUN, per edge: work[cnt] gets slice_result, the carry register gets slice_cout, and cnt increments.
- RUN at cnt=WIDTH-1, same edge:
  - overflow_int = slice_cin XOR slice_cout, for ADD/SUB only.
  - msb_sum = slice_result.
  - Next state is SLT_FIX for SLT, DONE otherwise.
- SLT_FIX (one cycle): drives s=11, binvert=1, cin=1, slice_a=A[0], slice_b=B[0], slice_less=msb_sum XOR overflow_int. On the edge, work gets {0…0, slice_result}, then the state goes to DONE.
- DONE (one cycle):
  - done=1.
  - result, zero and overflow were loaded from work/overflow_int on the edge that entered DONE.
  - Returns to IDLE next edge.
  - start in DONE is ignored.
- start in RUN or SLT_FIX is ignored; operands are not re-sampled.
- slice_less=0 in every state except SLT_FIX.
- In IDLE and DONE, all slice_* outputs are 0.

## Timing
- Accepting edge E0. Edges E1..E_WIDTH process bits 0..WIDTH-1.
- Non-SLT: done is high in the cycle after E_WIDTH, so latency = WIDTH cycles from the accepting edge.
- SLT: one extra SLT_FIX cycle; done is high in the cycle after E_(WIDTH+1).
- Minimum start-to-start spacing: WIDTH+2 cycles for non-SLT ops, WIDTH+3 cycles for SLT.
- result, zero and overflow change only on the edge entering DONE.
- Reset values: busy=0, done=0, result=0, zero=0, overflow=0, all slice_* outputs=0. Internal state: IDLE, cnt=0, carry=0.
- rst asserted mid-operation aborts immediately. No done pulse is produced; result keeps its reset value of 0.
- cnt is ceil(log2(WIDTH)) bits wide. cnt never wraps; the exit happens at WIDTH-1.

## Test plan
- WIDTH=8, ADD a=0x7F b=0x01 → done exactly 8 cycles after the accepting edge; result=0x80, overflow=1, zero=0. Bench checks busy high for cycles 1–8.
- SUB a=0x05 b=0x05 → result=0x00, zero=1, overflow=0. SUB a=0x80 b=0x01 → result=0x7F, overflow=1.
- SLT a=0x80 b=0x01 → result=0x01, done 9 cycles after acceptance. SLT a=0x01 b=0x80 → result=0x00, zero=1. Both cases check slice_less only in SLT_FIX.
- AND 0xF0/0x3C → 0x30. OR → 0xFC. NOR 0xF0/0x0F → 0x00, zero=1. Illegal op 0101 → 0x00, overflow=0.
- start held high throughout an ADD → exactly one done pulse; the second operation is accepted only from IDLE, and operand changes mid-RUN have no effect.
- rst pulse at bit 4 of an ADD → all outputs 0 and state IDLE within the same cycle. A new start after reset deassertion then completes correctly.

Source files
------------

// File: rtl/serial_alu_if.sv
// Bundles the issue-side handshake, result bus and 1-bit ALU slice wires of serial_alu_ctrl.
// Latency: none, wires only.
// Backpressure: none; issue side sees busy/done, the slice is purely combinational.
// Modports:
//   master : issue logic  (drives start/op/a/b, sees busy/done/result/zero/overflow)
//   slave  : the sequencer (serial_alu_ctrl)
//   slice  : the external 1-bit ALU slice (sees slice controls, returns result/cout)
interface serial_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             slice_a;
  logic             slice_b;
  logic             slice_ainvert;
  logic             slice_binvert;
  logic             slice_cin;
  logic             slice_less;
  logic [1:0]       slice_s;
  logic             slice_result;
  logic             slice_cout;

  modport master (
    output start, op, a, b,
    input  busy, done, result, zero, overflow
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, zero, overflow,
    output slice_a, slice_b, slice_ainvert, slice_binvert, slice_cin, slice_less, slice_s,
    input  slice_result, slice_cout
  );

  modport slice (
    input  slice_a, slice_b, slice_ainvert, slice_binvert, slice_cin, slice_less, slice_s,
    output slice_result, slice_cout
  );
endinterface

// File: rtl/serial_alu_ctrl.sv
// Bit-serial MIPS-style ALU sequencer driving one external 1-bit ALU slice, LSB first.
// Latency: WIDTH cycles from the accepting edge to done (WIDTH+1 for SLT).
// Backpressure: start is only sampled in IDLE; busy is high in RUN/SLT_FIX, done pulses one cycle.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : serial_alu_if.slave -- start/op/a/b in, busy/done/result/zero/overflow out,
//              slice_* controls out, slice_result/slice_cout back from the slice
module serial_alu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  serial_alu_if.slave  bus
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    SLT_FIX = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] work;
  logic             msb_sum;
  // Raw signed-overflow of the last bit; kept for every op because SLT needs it
  // to correct the sign, but only reported on the overflow output for ADD/SUB.
  logic             ovf_int;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             overflow_r;

  logic             s_a;
  logic             s_b;
  logic             s_ainv;
  logic             s_binv;
  logic             s_cin;
  logic             s_less;
  logic [1:0]       s_sel;
  logic [WIDTH-1:0] work_nxt;

  logic             is_sub;
  logic             is_arith;
  logic             is_last;

  assign is_sub   = (op_r == OP_SUB) || (op_r == OP_SLT);
  assign is_arith = (op_r == OP_ADD) || (op_r == OP_SUB);
  assign is_last  = (cnt == LAST);

  // Slice controls are decoded from registered state only, so they are stable
  // for the whole cycle and the slice settles before the next edge.
  always_comb begin
    s_a    = 1'b0;
    s_b    = 1'b0;
    s_ainv = 1'b0;
    s_binv = 1'b0;
    s_cin  = 1'b0;
    s_less = 1'b0;
    s_sel  = 2'b00;
    case (state)
      RUN: begin
        s_a   = a_r[cnt];
        s_b   = b_r[cnt];
        s_cin = (cnt == '0) ? is_sub : carry;
        case (op_r)
          OP_AND: s_sel = 2'b00;
          OP_OR:  s_sel = 2'b01;
          OP_ADD: s_sel = 2'b10;
          OP_SUB,
          OP_SLT: begin
            s_sel  = 2'b10;
            s_binv = 1'b1;
          end
          OP_NOR: begin
            s_sel  = 2'b00;
            s_ainv = 1'b1;
            s_binv = 1'b1;
          end
          default: begin
            // Unknown code: AND with a forced-zero A bit gives a zero result.
            s_sel = 2'b00;
            s_a   = 1'b0;
          end
        endcase
      end
      SLT_FIX: begin
        s_a    = a_r[0];
        s_b    = b_r[0];
        s_sel  = 2'b11;
        s_binv = 1'b1;
        s_cin  = 1'b1;
        // True sign of a-b is the MSB of the difference corrected by overflow.
        s_less = msb_sum ^ ovf_int;
      end
      default: ;
    endcase
  end

  // Work register with the current bit merged in, so the edge leaving RUN can
  // load result/zero from the complete value.
  always_comb begin
    work_nxt      = work;
    work_nxt[cnt] = bus.slice_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      carry      <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      op_r       <= '0;
      work       <= '0;
      msb_sum    <= 1'b0;
      ovf_int    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      result_r   <= '0;
      zero_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r    <= bus.a;
            b_r    <= bus.b;
            op_r   <= bus.op;
            cnt    <= '0;
            carry  <= 1'b0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          work  <= work_nxt;
          carry <= bus.slice_cout;
          if (is_last) begin
            msb_sum <= bus.slice_result;
            ovf_int <= s_cin ^ bus.slice_cout;
            if (op_r == OP_SLT) begin
              state <= SLT_FIX;
            end else begin
              result_r   <= work_nxt;
              zero_r     <= (work_nxt == '0);
              overflow_r <= is_arith & (s_cin ^ bus.slice_cout);
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              state      <= DONE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SLT_FIX: begin
          work       <= {{(WIDTH-1){1'b0}}, bus.slice_result};
          result_r   <= {{(WIDTH-1){1'b0}}, bus.slice_result};
          zero_r     <= ~bus.slice_result;
          overflow_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.result        = result_r;
  assign bus.zero          = zero_r;
  assign bus.overflow      = overflow_r;
  assign bus.slice_a       = s_a;
  assign bus.slice_b       = s_b;
  assign bus.slice_ainvert = s_ainv;
  assign bus.slice_binvert = s_binv;
  assign bus.slice_cin     = s_cin;
  assign bus.slice_less    = s_less;
  assign bus.slice_s       = s_sel;

endmodule
